// File: rtl/eth_frame_pattern_mem_arbiter.sv
// Two-requester arbiter in front of one pattern memory port, plus a zero-fill
// clear engine. Round-robin between s0 and s1; a pending clear wins over
// both once any in-flight transaction has been acknowledged.
module eth_frame_pattern_mem_arbiter #(
    parameter int C_AXI_WIDTH  = 32,
    parameter int C_ADDR_WIDTH = 11,
    parameter int C_MEM_DEPTH  = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s0_req,
    input  logic                    s0_we,
    input  logic [C_ADDR_WIDTH-1:0] s0_addr,
    input  logic [C_AXI_WIDTH-1:0]  s0_wdata,
    output logic                    s0_ack,
    output logic [C_AXI_WIDTH-1:0]  s0_rdata,
    input  logic                    s1_req,
    input  logic                    s1_we,
    input  logic [C_ADDR_WIDTH-1:0] s1_addr,
    input  logic [C_AXI_WIDTH-1:0]  s1_wdata,
    output logic                    s1_ack,
    output logic [C_AXI_WIDTH-1:0]  s1_rdata,
    input  logic                    clear_start,
    output logic                    clear_busy,
    output logic                    clear_done,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [C_ADDR_WIDTH-1:0] mem_addr,
    output logic [C_AXI_WIDTH-1:0]  mem_wdata,
    input  logic                    mem_ack,
    input  logic [C_AXI_WIDTH-1:0]  mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GNT0,
        ST_GNT1,
        ST_RSP0,
        ST_RSP1,
        ST_CLR
    } state_t;

    localparam logic [C_ADDR_WIDTH-1:0] LAST_ADDR = C_ADDR_WIDTH'(C_MEM_DEPTH - 1);

    state_t                    state_reg, state_next;
    logic                      last_grant_reg;
    logic                      clear_pending_reg;
    logic                      clear_busy_reg;
    logic                      clear_done_reg;
    logic [C_ADDR_WIDTH-1:0]   clr_cnt_reg;
    logic                      mem_req_reg;
    logic                      mem_we_reg;
    logic [C_ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [C_AXI_WIDTH-1:0]    mem_wdata_reg;

    // Requester-side inputs gathered into indexable form
    logic [1:0]                req_vec;
    logic [1:0]                we_vec;
    logic [C_ADDR_WIDTH-1:0]   addr_arr  [2];
    logic [C_AXI_WIDTH-1:0]    wdata_arr [2];
    logic [1:0]                in_gnt;
    logic                      grant_sel;
    logic                      mem_done;

    assign req_vec      = {s1_req, s0_req};
    assign we_vec       = {s1_we, s0_we};
    assign addr_arr[0]  = s0_addr;
    assign addr_arr[1]  = s1_addr;
    assign wdata_arr[0] = s0_wdata;
    assign wdata_arr[1] = s1_wdata;
    assign in_gnt       = {state_reg == ST_GNT1, state_reg == ST_GNT0};
    // An ack only counts while we actually have a request outstanding
    assign mem_done     = mem_ack & mem_req_reg;
    assign grant_sel    = (state_next == ST_GNT1);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: clear first, then single requester, ties to the one not granted last
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (clear_pending_reg) begin
                    state_next = ST_CLR;
                end else if (req_vec == 2'b11) begin
                    state_next = last_grant_reg ? ST_GNT0 : ST_GNT1;
                end else if (req_vec[0]) begin
                    state_next = ST_GNT0;
                end else if (req_vec[1]) begin
                    state_next = ST_GNT1;
                end
            end
            ST_GNT0: if (mem_done) state_next = ST_RSP0;
            ST_GNT1: if (mem_done) state_next = ST_RSP1;
            ST_RSP0: state_next = ST_IDLE;
            ST_RSP1: state_next = ST_IDLE;
            ST_CLR:  if (mem_done && (clr_cnt_reg == LAST_ADDR)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory-side request, round-robin pointer and clear engine bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg    <= 1'b1;
            clear_pending_reg <= 1'b0;
            clear_busy_reg    <= 1'b0;
            clear_done_reg    <= 1'b0;
            clr_cnt_reg       <= '0;
            mem_req_reg       <= 1'b0;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= '0;
            mem_wdata_reg     <= '0;
        end else begin
            clear_done_reg <= 1'b0;
            if (clear_start && !clear_busy_reg) begin
                clear_pending_reg <= 1'b1;
                clear_busy_reg    <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (state_next == ST_CLR) begin
                        clear_pending_reg <= 1'b0;
                        mem_req_reg       <= 1'b1;
                        mem_we_reg        <= 1'b1;
                        mem_wdata_reg     <= '0;
                        mem_addr_reg      <= clr_cnt_reg;
                    end else if (state_next != ST_IDLE) begin
                        mem_req_reg    <= 1'b1;
                        mem_we_reg     <= we_vec[grant_sel];
                        mem_addr_reg   <= addr_arr[grant_sel];
                        mem_wdata_reg  <= wdata_arr[grant_sel];
                        last_grant_reg <= grant_sel;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (mem_done) mem_req_reg <= 1'b0;
                end
                ST_CLR: begin
                    // One idle cycle between words lets the memory see a fresh request
                    if (mem_done) begin
                        mem_req_reg <= 1'b0;
                        if (clr_cnt_reg == LAST_ADDR) begin
                            clr_cnt_reg    <= '0;
                            clear_busy_reg <= 1'b0;
                            clear_done_reg <= 1'b1;
                        end else begin
                            clr_cnt_reg <= clr_cnt_reg + 1'b1;
                        end
                    end else if (!mem_req_reg) begin
                        mem_req_reg  <= 1'b1;
                        mem_addr_reg <= clr_cnt_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-requester ack pulse and held read data
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_rsp
            logic                   ack_reg;
            logic [C_AXI_WIDTH-1:0] rdata_reg;

            // Capture read data and raise ack together on the granted requester's completion
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= in_gnt[gi] & mem_done;
                    if (in_gnt[gi] && mem_done) rdata_reg <= mem_rdata;
                end
            end
        end
    endgenerate

    assign s0_ack     = gen_rsp[0].ack_reg;
    assign s0_rdata   = gen_rsp[0].rdata_reg;
    assign s1_ack     = gen_rsp[1].ack_reg;
    assign s1_rdata   = gen_rsp[1].rdata_reg;
    assign clear_busy = clear_busy_reg;
    assign clear_done = clear_done_reg;
    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_eth_frame_pattern_mem_arbiter.sv
// Scoreboard bench for eth_frame_pattern_mem_arbiter: stimulus pushes the
// expected memory operations / acks / clear_done events in order, a monitor
// pops and compares whenever the DUT presents one.
module tb_eth_frame_pattern_mem_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    localparam int K_MEM  = 0;
    localparam int K_ACK0 = 1;
    localparam int K_ACK1 = 2;
    localparam int K_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_req = 1'b0, s0_we = 1'b0;
    logic [AW-1:0] s0_addr = '0;
    logic [DW-1:0] s0_wdata = '0;
    logic          s0_ack;
    logic [DW-1:0] s0_rdata;
    logic          s1_req = 1'b0, s1_we = 1'b0;
    logic [AW-1:0] s1_addr = '0;
    logic [DW-1:0] s1_wdata = '0;
    logic          s1_ack;
    logic [DW-1:0] s1_rdata;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    typedef struct {
        int            kind;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            chk;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // memory model state
    bit [DW-1:0] mem_model [0:2047];
    bit          init_done = 1'b0;
    bit          served = 1'b0;
    int          lat_cnt = 0;
    int          mem_lat = 1;

    always #5 clk = ~clk;

    eth_frame_pattern_mem_arbiter #(
        .C_AXI_WIDTH (DW),
        .C_ADDR_WIDTH(AW),
        .C_MEM_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0_req     (s0_req),
        .s0_we      (s0_we),
        .s0_addr    (s0_addr),
        .s0_wdata   (s0_wdata),
        .s0_ack     (s0_ack),
        .s0_rdata   (s0_rdata),
        .s1_req     (s1_req),
        .s1_we      (s1_we),
        .s1_addr    (s1_addr),
        .s1_wdata   (s1_wdata),
        .s1_ack     (s1_ack),
        .s1_rdata   (s1_rdata),
        .clear_start(clear_start),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: acks once per request after mem_lat cycles, forgets a dropped request
    always @(posedge clk) begin
        mem_ack <= 1'b0;
        if (!init_done) begin
            mem_model[3]      <= 32'hAAAA5555;
            mem_model[32]     <= 32'hC0FFEE11;
            mem_model[2047]   <= 32'h12345678;
            init_done         <= 1'b1;
        end
        if (!mem_req) begin
            served  <= 1'b0;
            lat_cnt <= 0;
        end else if (!served) begin
            if (lat_cnt >= mem_lat - 1) begin
                mem_ack <= 1'b1;
                served  <= 1'b1;
                lat_cnt <= 0;
                if (mem_we) mem_model[mem_addr] <= mem_wdata;
                else        mem_rdata <= mem_model[mem_addr];
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic observe(input int kind, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
        ev_t e;
        bit  bad;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=0x%0h data=0x%0h, required no event",
                     kind, addr, data);
        end else begin
            e   = exp_q.pop_front();
            bad = (e.kind != kind) ||
                  (kind == K_MEM && (e.we != we || e.addr != addr)) ||
                  (e.chk && e.data != data);
            if (bad) begin
                n_bad++;
                $display("FAIL scoreboard: got kind=%0d we=%0d addr=0x%0h data=0x%0h, required kind=%0d we=%0d addr=0x%0h data=0x%0h",
                         kind, we, addr, data, e.kind, e.we, e.addr, e.data);
            end else begin
                $display("t=%0t event kind=%0d we=%0d addr=0x%0h data=0x%0h ok", $time, kind, we, addr, data);
            end
        end
    endtask

    function automatic void push_ev(input int kind, input bit we, input logic [AW-1:0] addr,
                                    input logic [DW-1:0] data, input bit chk);
        ev_t e;
        e.kind = kind;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        e.chk  = chk;
        exp_q.push_back(e);
    endfunction

    function automatic void push_clear();
        for (int i = 0; i < DEPTH; i++) push_ev(K_MEM, 1'b1, AW'(i), '0, 1'b1);
        push_ev(K_DONE, 1'b0, '0, '0, 1'b0);
    endfunction

    // Monitor: pops one expectation per presented event
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req && mem_ack) observe(K_MEM, mem_we, mem_addr, mem_wdata);
            if (s0_ack) observe(K_ACK0, 1'b0, '0, s0_rdata);
            if (s1_ack) observe(K_ACK1, 1'b0, '0, s1_rdata);
            if (clear_done) begin
                observe(K_DONE, 1'b0, '0, '0);
                check("busy_falls_with_done", 64'(clear_busy), 64'd0);
            end
        end
    end

    // One requester transaction; call just after a rising edge
    task automatic xact(input int id, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        int n = 0;
        if (id == 0) begin
            s0_we = we; s0_addr = addr; s0_wdata = wd; s0_req = 1'b1;
        end else begin
            s1_we = we; s1_addr = addr; s1_wdata = wd; s1_req = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!((id == 0) ? s0_ack : s1_ack) && n < 300);
        check($sformatf("s%0d_ack_in_time", id), 64'(n < 300), 64'd1);
        @(posedge clk);
        #1;
        if (id == 0) s0_req = 1'b0;
        else         s1_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!clear_done && n < 2000);
        check(name, 64'(n < 2000), 64'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 64'({s0_ack, s1_ack, clear_busy, clear_done, mem_req, mem_we}), 64'd0);
        check({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({name, "_rdata"}, {s0_rdata, s1_rdata}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // both requesters continuously from reset: order s0, s1, s0, s1
        mem_lat = 1;
        push_ev(K_MEM,  1'b1, 11'h100, 32'h11111111, 1'b1);
        push_ev(K_ACK0, 1'b0, '0, '0, 1'b0);
        push_ev(K_MEM,  1'b1, 11'h101, 32'h22222222, 1'b1);
        push_ev(K_ACK1, 1'b0, '0, '0, 1'b0);
        push_ev(K_MEM,  1'b0, 11'h100, '0, 1'b0);
        push_ev(K_ACK0, 1'b0, '0, 32'h11111111, 1'b1);
        push_ev(K_MEM,  1'b0, 11'h101, '0, 1'b0);
        push_ev(K_ACK1, 1'b0, '0, 32'h22222222, 1'b1);
        fork
            begin
                xact(0, 1'b1, 11'h100, 32'h11111111);
                @(posedge clk); #1;
                xact(0, 1'b0, 11'h100, '0);
            end
            begin
                xact(1, 1'b1, 11'h101, 32'h22222222);
                @(posedge clk); #1;
                xact(1, 1'b0, 11'h101, '0);
            end
        join

        // s0 write latency, 1-cycle memory
        repeat (2) @(posedge clk);
        #1;
        push_ev(K_MEM,  1'b1, 11'h005, 32'hDEADBEEF, 1'b1);
        push_ev(K_ACK0, 1'b0, '0, '0, 1'b0);
        s0_we = 1'b1; s0_addr = 11'h005; s0_wdata = 32'hDEADBEEF; s0_req = 1'b1;
        @(negedge clk);
        check("t1_no_mem_req_yet", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("t1_mem_req", 64'(mem_req), 64'd1);
        check("t1_mem_we", 64'(mem_we), 64'd1);
        check("t1_mem_addr", 64'(mem_addr), 64'h005);
        check("t1_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        @(negedge clk);
        check("t1_ack_not_early", 64'(s0_ack), 64'd0);
        @(negedge clk);
        check("t1_s0_ack", 64'(s0_ack), 64'd1);
        check("t1_s1_ack_quiet", 64'(s1_ack), 64'd0);
        @(posedge clk);
        #1;
        s0_req = 1'b0;
        @(negedge clk);
        check("t1_ack_single", 64'(s0_ack), 64'd0);

        // s1 read of the top address, 3-cycle memory
        @(posedge clk);
        #1;
        mem_lat = 3;
        push_ev(K_MEM,  1'b0, 11'h7FF, '0, 1'b0);
        push_ev(K_ACK1, 1'b0, '0, 32'h12345678, 1'b1);
        xact(1, 1'b0, 11'h7FF, '0);
        @(negedge clk);
        check("t2_ack_single", 64'(s1_ack), 64'd0);
        check("t2_rdata_held", 64'(s1_rdata), 64'h12345678);

        // clear of 16 words, s0 read raised mid-clear is served afterwards
        @(posedge clk);
        #1;
        mem_lat = 1;
        push_clear();
        push_ev(K_MEM,  1'b0, 11'h003, '0, 1'b0);
        push_ev(K_ACK0, 1'b0, '0, 32'h0, 1'b1);
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        @(negedge clk);
        check("t3_busy_set", 64'(clear_busy), 64'd1);
        fork
            wait_done("t3_clear_done_seen");
            begin
                repeat (8) @(posedge clk);
                #1;
                xact(0, 1'b0, 11'h003, '0);
            end
        join

        // clear_start while GNT1 waits; a second clear_start during CLR is ignored
        @(posedge clk);
        #1;
        mem_lat = 6;
        push_ev(K_MEM,  1'b1, 11'h010, 32'h0BADF00D, 1'b1);
        push_ev(K_ACK1, 1'b0, '0, '0, 1'b0);
        push_clear();
        fork
            xact(1, 1'b1, 11'h010, 32'h0BADF00D);
            begin
                repeat (2) @(posedge clk);
                #1;
                clear_start = 1'b1;
                @(posedge clk);
                #1;
                clear_start = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        check("t5_busy_in_clear", 64'(clear_busy), 64'd1);
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        wait_done("t5_clear_done_seen");
        repeat (30) @(negedge clk);
        check("t5_no_second_clear", 64'({clear_busy, mem_req}), 64'd0);

        // asynchronous reset while GNT0 waits on the memory, then retry
        @(posedge clk);
        #1;
        mem_lat = 8;
        s0_we = 1'b0; s0_addr = 11'h020; s0_wdata = '0; s0_req = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_gnt0_waiting", 64'(mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        s0_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_lat = 2;
        push_ev(K_MEM,  1'b0, 11'h020, '0, 1'b0);
        push_ev(K_ACK0, 1'b0, '0, 32'hC0FFEE11, 1'b1);
        xact(0, 1'b0, 11'h020, '0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eth_frame_pattern_mem_arbiter.md
Name: eth_frame_pattern_mem_arbiter

Overview:
Shares the port-A request/ack interface of one pattern memory between two requesters: s0 is the AXI register path and s1 is a secondary pattern loader. It also contains a clear engine that zero-fills the whole memory on command. One instance sits in front of each pattern memory, in the s_axi_clk domain.

Parameters:
C_AXI_WIDTH, 32, data width of every wdata/rdata bus.
C_ADDR_WIDTH, 11, word address width.
C_MEM_DEPTH, 2048, words cleared by the clear engine; must be ≤ 2**C_ADDR_WIDTH.

Ports:
clk  in  1  single clock, s_axi_clk domain.
rst_n  in  1  asynchronous active-low reset.
s0_req / s0_we  in  1 / 1  requester 0 request and write-enable.
s0_addr / s0_wdata  in  C_ADDR_WIDTH / C_AXI_WIDTH  requester 0 address and write data.
s0_ack  out  1  one-cycle completion pulse for requester 0.
s0_rdata  out  C_AXI_WIDTH  read data, valid while s0_ack=1.
s1_req, s1_we, s1_addr, s1_wdata, s1_ack, s1_rdata  same widths/directions as s0_*, for requester 1.
clear_start  in  1  pulse; starts a zero-fill.
clear_busy  out  1  high while a clear is pending or running.
clear_done  out  1  one-cycle pulse when the clear finishes.
mem_req / mem_we  out  1 / 1  memory-side request and write-enable.
mem_addr / mem_wdata  out  C_ADDR_WIDTH / C_AXI_WIDTH  memory-side address and write data.
mem_ack  in  1  one-cycle memory completion pulse.
mem_rdata  in  C_AXI_WIDTH  memory read data, valid with mem_ack.

Behaviour:
- Handshake, both sides:
  - A requester holds req/we/addr/wdata stable until it sees ack=1, then drops req the next cycle.
  - mem_ack is a single-cycle pulse, any number of cycles ≥1 after mem_req rises.
- Reset: every output is 0. State is IDLE, last_grant=1 (s0 wins the first tie), clear_pending=0, clear counter=0.
- FSM states: IDLE, GNT0, GNT1, RSP0, RSP1, CLR.
  - IDLE priority: clear_pending → CLR; else one requester → its GNTx; both → the one not equal to last_grant.
  - Entering GNTx: register mem_req=1 and copy sx_we/addr/wdata onto mem_*; update last_grant=x.
  - GNTx: wait for mem_ack. On mem_ack, mem_req←0, sx_rdata←mem_rdata, → RSPx.
  - RSPx: sx_ack=1 for exactly this cycle, → IDLE. This cycle absorbs the requester's stale req.
  - CLR: mem_req=1, mem_we=1, mem_wdata=0, mem_addr=counter.
    - On each mem_ack: counter+1, with mem_req dropped for one cycle between words.
    - After the ack for address C_MEM_DEPTH-1: counter←0, clear_busy←0, clear_done=1 for one cycle, → IDLE.
- Latency with a memory that acks the cycle after req:
  - req seen at edge N → mem_req high N+1 → mem_ack N+2 → sx_ack N+3.
  - Next grant starts at N+4 at the earliest.
- clear_start handling:
  - Sets clear_pending and clear_busy on the next edge.
  - An in-flight GNTx/RSPx transaction finishes first; then CLR has priority over both requesters.
  - Ignored while clear_busy=1.
- Requests during CLR are stalled, not dropped; they are served in round-robin order afterwards.
- sx_rdata holds its value until the next read completion for that requester. Write completions also update it (value is don't-care).
- mem_we/addr/wdata hold their value when mem_req=0.
- Reset mid-operation: abort immediately with no ack or done pulse. The memory side must tolerate the dropped request.
- A mem_ack with no outstanding mem_req is ignored.

Test Plan:
- s0 write: addr=0x005, wdata=0xDEADBEEF, 1-cycle memory → mem_we=1 and addr 0x005 at N+1; s0_ack only at N+3; s1_ack stays 0.
- s1 read: addr=0x7FF, memory returns 0x12345678 after 3 cycles → s1_rdata=0x12345678 while s1_ack=1, exactly one pulse.
- s0 and s1 requesting continuously from reset, 4 transactions → grant order s0, s1, s0, s1.
- clear_start with C_MEM_DEPTH=16 → 16 writes of 0 at addresses 0..15 in order; clear_done pulses once; clear_busy falls the same edge.
  - s0_req raised mid-clear is served only after clear_done.
- clear_start while GNT1 waits on mem_ack → s1 completes first, then CLR begins; second clear_start during CLR → no extra clear.
- rst_n low while GNT0 waits → all outputs 0 immediately; after release, s0 retries and completes normally.
